// File: rtl/fifo_pack_pkg.sv
// Shared constants and types for the FIFO read-side byte packer.
// Word geometry, counter width, FSM states and the keep-mask helper.
package fifo_pack_pkg;

    localparam int DATA_WIDTH     = 8;
    localparam int BYTES_PER_WORD = 4;
    localparam int WORD_WIDTH     = DATA_WIDTH * BYTES_PER_WORD;
    localparam int CNT_WIDTH      = 3;
    localparam int LANE_WIDTH     = $clog2(BYTES_PER_WORD);

    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(BYTES_PER_WORD);

    typedef enum logic [1:0] {
        FILL,
        DRAIN,
        EMIT,
        DONE
    } pack_state_t;

    // (1 << n) - 1, built lane by lane so n == BYTES_PER_WORD gives all ones
    function automatic logic [BYTES_PER_WORD-1:0] keep_mask(
        input logic [CNT_WIDTH-1:0] n
    );
        logic [BYTES_PER_WORD-1:0] m;
        m = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (CNT_WIDTH'(i) < n) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/pack_out_reg.sv
// One-entry output register for packed words.
// Loads when empty or draining; holds data/keep/last while stalled.
module pack_out_reg
    import fifo_pack_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic [WORD_WIDTH-1:0]     load_data,
    input  logic [BYTES_PER_WORD-1:0] load_keep,
    input  logic                      load_last,
    input  logic                      out_ready,
    output logic [WORD_WIDTH-1:0]     out_data,
    output logic [BYTES_PER_WORD-1:0] out_keep,
    output logic                      out_last,
    output logic                      out_valid,
    output logic                      can_load
);

    assign can_load = !out_valid || out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_data  <= '0;
            out_keep  <= '0;
            out_last  <= 1'b0;
            out_valid <= 1'b0;
        end else if (load) begin
            out_data  <= load_data;
            out_keep  <= load_keep;
            out_last  <= load_last;
            out_valid <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_read_packer.sv
// Pops bytes from cdc_fifo and packs them little-endian into words.
// A flush closes the current word with byte enables and a last marker.
module fifo_read_packer
    import fifo_pack_pkg::*;
(
    input  logic                      read_clk,
    input  logic                      read_rst,
    input  logic                      fifo_empty,
    output logic                      read_enable,
    input  logic [DATA_WIDTH-1:0]     read_data,
    input  logic                      flush,
    output logic                      flush_done,
    output logic [WORD_WIDTH-1:0]     out_data,
    output logic [BYTES_PER_WORD-1:0] out_keep,
    output logic                      out_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic                      busy
);

    pack_state_t state, state_nxt;

    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] acc;
    logic [BYTES_PER_WORD-1:0][DATA_WIDTH-1:0] emit_data;
    logic [CNT_WIDTH-1:0]      cnt, cnt_base, inflight;
    logic [LANE_WIDTH-1:0]     cap_lane;
    logic [BYTES_PER_WORD-1:0] emit_keep;
    logic [WORD_WIDTH-1:0]     load_data;
    logic [BYTES_PER_WORD-1:0] load_keep;
    logic pending;
    logic can_load;
    logic word_move;
    logic emit_load;
    logic load;

    assign inflight = cnt + {{(CNT_WIDTH-1){1'b0}}, pending};

    assign read_enable = !read_rst && state == FILL &&
                         !fifo_empty && inflight < CNT_FULL;

    always_comb begin
        state_nxt  = state;
        word_move  = 1'b0;
        emit_load  = 1'b0;
        unique case (state)
            FILL: begin
                // a flush takes priority so a full word leaves via EMIT with last set
                if (flush) state_nxt = DRAIN;
                else if (cnt == CNT_FULL && can_load) word_move = 1'b1;
            end
            DRAIN: begin
                if (!pending) state_nxt = (cnt == '0) ? DONE : EMIT;
            end
            EMIT: begin
                if (can_load) begin
                    emit_load = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = FILL;
            end
        endcase
    end

    assign flush_done = !read_rst && state == DONE;

    assign busy = !read_rst &&
                  !(state == FILL && cnt == '0 && !pending && !out_valid);

    assign load = word_move || emit_load;

    assign emit_keep = keep_mask(cnt);

    always_comb begin
        emit_data = '0;
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
            if (emit_keep[i]) emit_data[i] = acc[i];
        end
    end

    assign load_data = word_move ? acc : emit_data;
    assign load_keep = word_move ? '1 : emit_keep;

    assign cnt_base = load ? '0 : cnt;
    assign cap_lane = cnt_base[LANE_WIDTH-1:0];

    always_ff @(posedge read_clk) begin
        if (read_rst) begin
            state   <= FILL;
            cnt     <= '0;
            pending <= 1'b0;
            acc     <= '0;
        end else begin
            state   <= state_nxt;
            pending <= read_enable;
            cnt     <= cnt_base + {{(CNT_WIDTH-1){1'b0}}, pending};
            if (pending) acc[cap_lane] <= read_data;
        end
    end

    pack_out_reg u_out (
        .clk       (read_clk),
        .rst       (read_rst),
        .load      (load),
        .load_data (load_data),
        .load_keep (load_keep),
        .load_last (emit_load),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_keep  (out_keep),
        .out_last  (out_last),
        .out_valid (out_valid),
        .can_load  (can_load)
    );

endmodule
